shift_right_seq: RTL and testbench

- Multi-cycle n-bit right shifter for the RISC-V SRL/SRA/SRLI/SRAI path.
- Shifts the captured operand right by one bit per clock, for `shamt` clocks.
- Logical fill (0) or arithmetic fill (sign bit) is selected per operation.
- Sits beside the ALU. The control unit launches it with `start` and stalls until `done`.

---
 rtl/shift_right_seq.sv | 99 +++++++++
 tb/tb_shift_right_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter for SRL/SRA/SRLI/SRAI: one bit per clock, shamt clocks.
// Launched with start; busy while shifting, done pulses for one cycle when b is updated.
module shift_right_seq #(
  parameter  int unsigned n  = 32,
  localparam int unsigned SW = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [n-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic          arith,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  data_q, data_d;
  logic [SW-1:0] count_q, count_d;
  logic          fill_q, fill_d;
  logic [n-1:0]  b_d;
  logic          busy_d, done_d;
  logic [n-1:0]  shifted;

  assign shifted = {fill_q, data_q[n-1:1]};

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      b       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      b       <= b_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    fill_d  = fill_q;
    b_d     = b;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d  = a;
          count_d = shamt;
          fill_d  = arith & a[n-1];
          if (shamt == '0) begin
            // Nothing to shift: result is the operand itself
            state_d = DONE;
            b_d     = a;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d  = shifted;
        count_d = count_q - SW'(1);
        busy_d  = 1'b1;
        if (count_q == SW'(1)) begin
          state_d = DONE;
          b_d     = shifted;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: scoreboard of expected results,
// popped and compared whenever done pulses.
module tb_shift_right_seq;
  localparam int unsigned N  = 32;
  localparam int unsigned SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  a = '0;
  logic [SW-1:0] shamt = '0;
  logic          arith = 1'b0;
  logic          busy, done;
  logic [N-1:0]  b;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  shift_right_seq #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt),
    .arith(arith), .busy(busy), .done(done), .b(b)
  );

  function automatic logic [N-1:0] model(input logic [N-1:0] x, input logic [SW-1:0] s,
                                         input logic ar);
    if (ar) model = N'($signed(x) >>> s);
    else    model = x >> s;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    logic [N-1:0] e;
    if (rst && done) begin
      done_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: b=%h with no result outstanding", b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e) begin
          errors++;
          $display("FAIL result: b=%h required %h", b, e);
        end
      end
    end
  end

  // Leaves the bench at the negedge of the first cycle after the accepting edge
  task automatic launch(input logic [N-1:0] x, input logic [SW-1:0] s, input logic ar,
                        input bit expect_it);
    @(negedge clk);
    start = 1'b1; a = x; shamt = s; arith = ar;
    if (expect_it) exp_q.push_back(model(x, s, ar));
    @(negedge clk);
    start = 1'b0; a = N'($urandom); shamt = SW'($urandom); arith = ~ar;
  endtask

  task automatic wait_done(input string name, input int s);
    int lat = 1;
    int bc  = 0;
    while (!done && lat <= int'(N) + 4) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != s + 1) begin
      errors++;
      $display("FAIL %s latency: done in cycle %0d required %0d", name, lat, s + 1);
    end
    checks++;
    if (bc != s) begin
      errors++;
      $display("FAIL %s busy_cycles: %0d required %0d", name, bc, s);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] x, input logic [SW-1:0] s,
                        input logic ar);
    launch(x, s, ar, 1'b1);
    wait_done(name, int'(s));
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || b !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b b=%h required 0 0 0", busy, done, b);
    end
    rst = 1'b1;
    launch(32'hFFFF_0000, SW'(20), 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: busy=%b required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || b !== '0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b b=%h required 0 0 0", busy, done, b);
    end
    @(negedge clk);
    rst = 1'b1;
    begin
      int ds0 = done_seen;
      repeat (30) @(negedge clk);
      checks++;
      if (done_seen != ds0 || b !== '0) begin
        errors++;
        $display("FAIL reset_abort: done pulses=%0d b=%h required 0 and 0", done_seen - ds0, b);
      end
    end
    run_op("post_reset", 32'h0000_00F0, SW'(4), 1'b0);
  endtask

  task automatic test_srl;
    run_op("srl4", 32'h8000_00F0, SW'(4), 1'b0);
    run_op("srl31", 32'h8000_0001, SW'(31), 1'b0);
  endtask

  task automatic test_sra;
    run_op("sra4", 32'h8000_00F0, SW'(4), 1'b1);
    run_op("sra31", 32'h8000_00F0, SW'(31), 1'b1);
    run_op("sra_pos", 32'h7000_0000, SW'(5), 1'b1);
  endtask

  task automatic test_zero;
    launch(32'h1234_5678, SW'(0), 1'b1, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_latency: done=%b busy=%b required 1 0", done, busy);
    end
    // Restart with another zero shift while done is high: done must stay high
    start = 1'b1; a = 32'hCAFE_F00D; shamt = SW'(0); arith = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    start = 1'b0; a = N'($urandom);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_b2b: done=%b busy=%b required 1 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_drop: done=%b required 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int k = 0;
    launch(32'h0000_0100, SW'(3), 1'b0, 1'b1);
    start = 1'b1; a = 32'hFFFF_FFFF; shamt = SW'(1); arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL b2b_first_done: %0d cycles after ignored start, required 2", k);
    end
    start = 1'b1; a = 32'h0000_0040; shamt = SW'(2); arith = 1'b0;
    exp_q.push_back(32'h0000_0010);
    @(negedge clk);
    start = 1'b0; a = N'($urandom);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy%0d: busy=%b done=%b required 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b busy=%b required 1 0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_input_change;
    run_op("input_change", 32'hF000_0000, SW'(8), 1'b1);
  endtask

  initial begin
    test_reset();
    test_srl();
    test_sra();
    test_zero();
    test_back_to_back();
    test_input_change();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
